// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply and restoring divide
// on operand magnitudes, with sign fix-up applied when the result is written.
module muldiv_unit #(
    parameter bit EARLY_OUT = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output logic        busy,
    output logic [31:0] rd,
    output logic        rdWriteEnable
);

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t      state_reg, state_next;
    logic [5:0]  count_reg, count_next;
    logic [1:0]  op_reg, op_next;
    logic [63:0] acc_reg, acc_next;
    logic [31:0] opnd_reg, opnd_next;
    logic        neg_reg, neg_next;
    logic        rneg_reg, rneg_next;
    logic [31:0] rd_reg, rd_next;

    logic        a_signed, b_signed, a_neg, b_neg;
    logic [31:0] a_mag, b_mag;
    logic        div_zero, div_ovf, fast;
    logic [32:0] mul_sum;
    logic        div_ge;
    logic [31:0] div_sub;
    logic [63:0] product;
    logic [31:0] quotient, remainder;

    // Operand decode at accept time
    always_comb begin
        a_signed = funct3[2] ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed = funct3[2] ? ~funct3[0] : ~funct3[1];
        a_neg    = a_signed & rs1[31];
        b_neg    = b_signed & rs2[31];
        a_mag    = a_neg ? -rs1 : rs1;
        b_mag    = b_neg ? -rs2 : rs2;
        div_zero = (rs2 == 32'h0);
        div_ovf  = ~funct3[0] && (rs1 == 32'h8000_0000) && (rs2 == 32'hFFFF_FFFF);
        fast     = EARLY_OUT && funct3[2] && (div_zero || div_ovf);
    end

    // acc holds {partial product, remaining multiplier} or {partial remainder, dividend/quotient}
    always_comb begin
        mul_sum   = {1'b0, acc_reg[63:32]} + {1'b0, (acc_reg[0] ? opnd_reg : 32'h0)};
        div_ge    = acc_reg[63:31] >= {1'b0, opnd_reg};
        div_sub   = acc_reg[62:31] - opnd_reg;
        product   = neg_reg ? -acc_reg : acc_reg;
        quotient  = neg_reg ? -acc_reg[31:0] : acc_reg[31:0];
        remainder = rneg_reg ? -acc_reg[63:32] : acc_reg[63:32];
    end

    always_comb begin
        state_next = state_reg;
        count_next = count_reg;
        op_next    = op_reg;
        acc_next   = acc_reg;
        opnd_next  = opnd_reg;
        neg_next   = neg_reg;
        rneg_next  = rneg_reg;
        rd_next    = rd_reg;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    op_next    = funct3[1:0];
                    count_next = 6'd0;
                    opnd_next  = funct3[2] ? b_mag : a_mag;
                    acc_next   = {32'h0, (funct3[2] ? a_mag : b_mag)};
                    // Zero divisor keeps the all-ones quotient un-negated
                    neg_next   = (a_neg ^ b_neg) & ~div_zero;
                    rneg_next  = a_neg;
                    state_next = funct3[2] ? DIV : MUL;
                    if (fast) begin
                        // Preload final quotient/remainder and skip the iterations
                        acc_next   = div_zero ? {rs1, 32'hFFFF_FFFF} : {32'h0, 32'h8000_0000};
                        neg_next   = 1'b0;
                        rneg_next  = 1'b0;
                        count_next = 6'd32;
                    end
                end
            end
            MUL: begin
                if (count_reg == 6'd32) begin
                    rd_next    = (op_reg == 2'b00) ? product[31:0] : product[63:32];
                    state_next = DONE;
                end else begin
                    acc_next   = {mul_sum, acc_reg[31:1]};
                    count_next = count_reg + 6'd1;
                end
            end
            DIV: begin
                if (count_reg == 6'd32) begin
                    rd_next    = op_reg[1] ? remainder : quotient;
                    state_next = DONE;
                end else begin
                    acc_next   = div_ge ? {div_sub, acc_reg[30:0], 1'b1} : {acc_reg[62:0], 1'b0};
                    count_next = count_reg + 6'd1;
                end
            end
            DONE: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg <= IDLE;
            count_reg <= 6'd0;
            op_reg    <= 2'b00;
            acc_reg   <= 64'h0;
            opnd_reg  <= 32'h0;
            neg_reg   <= 1'b0;
            rneg_reg  <= 1'b0;
            rd_reg    <= 32'h0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            op_reg    <= op_next;
            acc_reg   <= acc_next;
            opnd_reg  <= opnd_next;
            neg_reg   <= neg_next;
            rneg_reg  <= rneg_next;
            rd_reg    <= rd_next;
        end
    end

    assign busy          = (state_reg != IDLE);
    assign rdWriteEnable = (state_reg == DONE);
    assign rd            = rd_reg;

endmodule

// File: tb/tb_muldiv_unit.sv
// Testbench for muldiv_unit: drives an EARLY_OUT=1 and an EARLY_OUT=0 instance in parallel
// and compares results and write-pulse timing against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] rs1 = 32'h0;
    logic [31:0] rs2 = 32'h0;
    logic [1:0]  busy_v, we_v;
    logic [31:0] rd_v [2];

    int checks = 0;
    int failures = 0;

    always #5 clock = ~clock;

    muldiv_unit #(.EARLY_OUT(1'b1)) u_fast (
        .clock(clock), .reset(reset), .start(start), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .busy(busy_v[0]), .rd(rd_v[0]), .rdWriteEnable(we_v[0])
    );

    muldiv_unit #(.EARLY_OUT(1'b0)) u_slow (
        .clock(clock), .reset(reset), .start(start), .funct3(funct3),
        .rs1(rs1), .rs2(rs2), .busy(busy_v[1]), .rd(rd_v[1]), .rdWriteEnable(we_v[1])
    );

    typedef struct {
        logic [2:0]  f;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [12];

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ea, eb, p;
        int sa, sb;
        sa = a;
        sb = b;
        ea = ((f != 3'd3) && a[31]) ? {32'hFFFF_FFFF, a} : {32'h0, a};
        eb = ((f <= 3'd1) && b[31]) ? {32'hFFFF_FFFF, b} : {32'h0, b};
        p  = ea * eb;
        case (f)
            3'd0: return p[31:0];
            3'd1, 3'd2, 3'd3: return p[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(sa / sb);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(sa % sb);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a,
                                      input logic [31:0] b);
        return f[2] && ((b == 0) || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // One operation on both instances; cycle k is sampled 1 time unit after the k-th edge
    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp);
        int lat [2];
        int bad [2];
        logic [31:0] got [2];
        lat[0] = is_special(f, a, b) ? 2 : 34;
        lat[1] = 34;
        for (int d = 0; d < 2; d++) begin
            bad[d] = 0;
            got[d] = 'x;
        end
        funct3 = f;
        rs1 = a;
        rs2 = b;
        start = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 1) begin
                start = 1'b0;
                rs1 = $urandom;
                rs2 = $urandom;
                funct3 = 3'($urandom);
            end
            for (int d = 0; d < 2; d++) begin
                if (we_v[d] === 1'b1) got[d] = rd_v[d];
                if (we_v[d] !== (k == lat[d])) bad[d]++;
                if (busy_v[d] !== (k <= lat[d])) bad[d]++;
            end
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_rd_dut%0d", tag, d), got[d], exp);
            check($sformatf("%s_timing_errs_dut%0d", tag, d), 32'(bad[d]), 32'd0);
            check($sformatf("%s_rd_hold_dut%0d", tag, d), rd_v[d], exp);
        end
        $display("op %s f3=%0d a=%h b=%h exp=%h rd_fast=%h rd_slow=%h",
                 tag, f, a, b, exp, got[0], got[1]);
    endtask

    initial begin
        int pulses [2];
        int pulse_cyc [2];
        int busy_cnt [2];
        logic [31:0] got [2];

        vecs[0]  = '{3'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFEB};
        vecs[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000};
        vecs[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE};
        vecs[3]  = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        vecs[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD};
        vecs[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF};
        vecs[6]  = '{3'd5, 32'd100,       32'd7,         32'd14};
        vecs[7]  = '{3'd7, 32'd100,       32'd7,         32'd2};
        vecs[8]  = '{3'd5, 32'h1234,      32'd0,         32'hFFFF_FFFF};
        vecs[9]  = '{3'd6, 32'h1234,      32'd0,         32'h1234};
        vecs[10] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
        vecs[11] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0};

        // Reset held with start asserted: nothing may happen
        #2 reset = 1'b0;
        start = 1'b1;
        for (int k = 0; k < 5; k++) begin
            funct3 = 3'($urandom);
            rs1 = $urandom;
            rs2 = $urandom;
            tick();
            for (int d = 0; d < 2; d++) begin
                check($sformatf("reset_busy_dut%0d", d), 32'(busy_v[d]), 32'd0);
                check($sformatf("reset_we_dut%0d", d), 32'(we_v[d]), 32'd0);
                check($sformatf("reset_rd_dut%0d", d), rd_v[d], 32'd0);
            end
        end
        start = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            for (int d = 0; d < 2; d++)
                check($sformatf("idle_busy_dut%0d", d), 32'(busy_v[d] | we_v[d]), 32'd0);
        end
        $display("seq reset_hold done");

        for (int i = 0; i < 12; i++)
            run_op($sformatf("vec%0d", i), vecs[i].f, vecs[i].a, vecs[i].b, vecs[i].exp);

        // Start while busy: only the MUL 3x5 may complete
        for (int d = 0; d < 2; d++) begin
            pulses[d] = 0;
            pulse_cyc[d] = 0;
            got[d] = 'x;
        end
        funct3 = 3'd0;
        rs1 = 32'd3;
        rs2 = 32'd5;
        start = 1'b1;
        for (int k = 1; k <= 60; k++) begin
            tick();
            start = (k == 5 || k == 33 || k == 34);
            if (start) begin
                funct3 = 3'd4;
                rs1 = 32'd100;
                rs2 = 32'd7;
            end
            if (k == 10) begin
                rs1 = $urandom;
                rs2 = $urandom;
            end
            for (int d = 0; d < 2; d++) begin
                if (we_v[d] === 1'b1) begin
                    pulses[d]++;
                    pulse_cyc[d] = k;
                    got[d] = rd_v[d];
                end
            end
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("busy_start_pulses_dut%0d", d), 32'(pulses[d]), 32'd1);
            check($sformatf("busy_start_cycle_dut%0d", d), 32'(pulse_cyc[d]), 32'd34);
            check($sformatf("busy_start_rd_dut%0d", d), got[d], 32'd15);
            check($sformatf("busy_start_idle_dut%0d", d), 32'(busy_v[d]), 32'd0);
        end
        $display("seq start_while_busy rd_fast=%h rd_slow=%h pulses=%0d/%0d",
                 got[0], got[1], pulses[0], pulses[1]);

        // Reset in the middle of a divide
        funct3 = 3'd4;
        rs1 = 32'd1000;
        rs2 = 32'd3;
        start = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 1) start = 1'b0;
        end
        reset = 1'b0;
        #1;
        for (int d = 0; d < 2; d++) begin
            check($sformatf("midreset_busy_dut%0d", d), 32'(busy_v[d]), 32'd0);
            check($sformatf("midreset_we_dut%0d", d), 32'(we_v[d]), 32'd0);
            check($sformatf("midreset_rd_dut%0d", d), rd_v[d], 32'd0);
            pulses[d] = 0;
            busy_cnt[d] = 0;
        end
        tick();
        tick();
        @(negedge clock);
        reset = 1'b1;
        for (int k = 0; k < 40; k++) begin
            tick();
            for (int d = 0; d < 2; d++) begin
                if (we_v[d] !== 1'b0) pulses[d]++;
                if (busy_v[d] !== 1'b0) busy_cnt[d]++;
            end
        end
        for (int d = 0; d < 2; d++) begin
            check($sformatf("midreset_no_pulse_dut%0d", d), 32'(pulses[d]), 32'd0);
            check($sformatf("midreset_no_busy_dut%0d", d), 32'(busy_cnt[d]), 32'd0);
        end
        $display("seq mid_op_reset done");
        run_op("after_reset", 3'd4, 32'd1000, 32'd3, ref_model(3'd4, 32'd1000, 32'd3));

        // Randomized operations with biased corner operands
        for (int i = 0; i < 30; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'h0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 255);
                default: ;
            endcase
            run_op($sformatf("rand%0d", i), f, a, b, ref_model(f, a, b));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
